// File: rtl/fpaddsub_param_pkg.sv
// Shared types and helpers for the parametrised IEEE-754 adder/subtractor:
// FSM state encodings, flag bit positions, format sizing and leading-zero count.
package fpaddsub_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int GRS_W     = 3;
  localparam int LZC_W     = 128;

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // One integer bit, the stored fraction, then guard/round/sticky.
  function automatic int ext_w(input int man_w);
    return man_w + GRS_W + 1;
  endfunction

  // Callers left-align their value; an all-zero input returns LZC_W.
  function automatic int unsigned lzc(input logic [LZC_W-1:0] v);
    int unsigned n;
    logic        found;
    n     = 0;
    found = 1'b0;
    for (int i = LZC_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fpaddsub_param_if.sv
// Operand/result handshake bundle for fpaddsub_param; master drives operands
// and out_ready, slave (the adder) drives in_ready and the result side.
interface fpaddsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, sub, dataa, datab, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, sub, dataa, datab, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpaddsub_param_align_shift.sv
// Right shifter that saturates its amount and ORs every bit shifted out
// into the result LSB, keeping the sticky information of the lost tail.
module fpaddsub_param_align_shift #(
  parameter int WIDTH  = 27,
  parameter int AMT_W  = 8,
  parameter int MAX_SH = 26
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] out_o
);
  localparam int unsigned MAX_U = MAX_SH;

  int unsigned      sh;
  logic [WIDTH-1:0] lost_mask;

  always_comb begin
    sh = 32'(amt_i);
    if (sh > MAX_U) sh = MAX_U;
    lost_mask = ~({WIDTH{1'b1}} << sh);
    out_o     = in_i >> sh;
    out_o[0]  = out_o[0] | (|(in_i & lost_mask));
  end

endmodule

// File: rtl/fpaddsub_param.sv
// Multi-cycle IEEE-754 add/subtract with RNE rounding, specials and flags.
// One operation in flight: IDLE->ALIGN->ADD->NORM->ROUND->DONE.
module fpaddsub_param
  import fpaddsub_param_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic            clk,
  input  logic            reset_n,
  fpaddsub_param_if.slave bus
);
  localparam int W = word_w(EXP_W, MAN_W);
  localparam int X = ext_w(MAN_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  state_e state_q, state_d;

  logic [W-1:0]   a_q, b_q;
  logic           sx_q, eff_sub_q, spec_q, zero_q;
  logic [EXP_W:0] ex_q, en_q;
  logic [X-1:0]   mx_q, my_q, nm_q;
  logic [X:0]     sum_q;
  logic [W-1:0]   spec_res_q, result_q;
  logic [3:0]     spec_flg_q, flags_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // ALIGN: classify specials, order by magnitude, shift the smaller operand
  logic [W-1:0]     x_w, y_w;
  logic [EXP_W-1:0] xe, ye, diff;
  logic [X-1:0]     mx_d, my_d, sig_y;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic [W-1:0]     spec_res_d;
  logic [3:0]       spec_flg_d;
  logic             spec_d;

  always_comb begin
    x_w   = (a_q[W-2:0] >= b_q[W-2:0]) ? a_q : b_q;
    y_w   = (a_q[W-2:0] >= b_q[W-2:0]) ? b_q : a_q;
    xe    = (x_w[W-2:MAN_W] == '0) ? EXP_W'(1) : x_w[W-2:MAN_W];
    ye    = (y_w[W-2:MAN_W] == '0) ? EXP_W'(1) : y_w[W-2:MAN_W];
    diff  = xe - ye;
    mx_d  = {x_w[W-2:MAN_W] != '0, x_w[MAN_W-1:0], 3'b000};
    sig_y = {y_w[W-2:MAN_W] != '0, y_w[MAN_W-1:0], 3'b000};

    a_inf  = (a_q[W-2:MAN_W] == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
    b_inf  = (b_q[W-2:MAN_W] == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
    a_nan  = (a_q[W-2:MAN_W] == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
    b_nan  = (b_q[W-2:MAN_W] == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
    a_snan = a_nan && !a_q[MAN_W-1];
    b_snan = b_nan && !b_q[MAN_W-1];

    spec_d     = 1'b1;
    spec_res_d = QNAN;
    spec_flg_d = '0;
    if (a_nan || b_nan) begin
      spec_flg_d[FLG_INVALID] = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
      spec_flg_d[FLG_INVALID] = 1'b1;
    end else if (a_inf) begin
      spec_res_d = {a_q[W-1], EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res_d = {b_q[W-1], EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  fpaddsub_param_align_shift #(
    .WIDTH (X),
    .AMT_W (EXP_W),
    .MAX_SH(MAN_W + 3)
  ) u_align (
    .in_i (sig_y),
    .amt_i(diff),
    .out_o(my_d)
  );

  // ADD: x >= y in magnitude, so the difference never goes negative
  logic [X:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});

  // NORM: fold a carry back with sticky, then left-normalise down to exponent 1
  logic [X:0]     csh;
  logic [X-1:0]   v, nm_d;
  logic [EXP_W:0] ex_c, en_d;
  logic           norm_unused;
  int unsigned    lz, lim, lsh;

  fpaddsub_param_align_shift #(
    .WIDTH (X + 1),
    .AMT_W (1),
    .MAX_SH(1)
  ) u_carry (
    .in_i (sum_q),
    .amt_i(sum_q[X]),
    .out_o(csh)
  );

  always_comb begin
    norm_unused = csh[X];
    v    = csh[X-1:0];
    ex_c = ex_q + (EXP_W+1)'(sum_q[X]);
    lz   = lzc({v, {(LZC_W-X){1'b0}}});
    lim  = 32'(ex_c) - 32'd1;
    lsh  = (lz < lim) ? lz : lim;
    nm_d = v << lsh;
    en_d = ex_c - (EXP_W+1)'(lsh);
  end

  // ROUND: RNE on the G/R/S tail, then overflow/underflow classification
  logic             g, r, s, inc, inexact, ovf, tiny;
  logic [MAN_W+1:0] mr;
  logic [EXP_W:0]   er;
  logic [MAN_W-1:0] fr;
  logic [W-1:0]     res_d;
  logic [3:0]       flg_d;

  always_comb begin
    g       = nm_q[2];
    r       = nm_q[1];
    s       = nm_q[0];
    inc     = g & (r | s | nm_q[3]);
    inexact = g | r | s;
    mr      = {1'b0, nm_q[X-1:3]} + (MAN_W+2)'(inc);
    if (mr[MAN_W+1]) begin
      er = en_q + 1'b1;
      fr = mr[MAN_W:1];
    end else begin
      er = mr[MAN_W] ? en_q : '0;
      fr = mr[MAN_W-1:0];
    end
    ovf  = (er >= {1'b0, EXP_ONES});
    tiny = (er == '0);

    res_d = {sx_q, er[EXP_W-1:0], fr};
    flg_d = '0;
    flg_d[FLG_INEXACT]   = inexact;
    flg_d[FLG_UNDERFLOW] = tiny & inexact;
    if (spec_q) begin
      res_d = spec_res_q;
      flg_d = spec_flg_q;
    end else if (zero_q) begin
      res_d = {~eff_sub_q & sx_q, {(W-1){1'b0}}};
      flg_d = '0;
    end else if (ovf) begin
      res_d = {sx_q, EXP_ONES, {MAN_W{1'b0}}};
      flg_d = '0;
      flg_d[FLG_OVERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        a_q <= bus.dataa;
        b_q <= {bus.datab[W-1] ^ bus.sub, bus.datab[W-2:0]};
      end
      S_ALIGN: begin
        sx_q       <= x_w[W-1];
        eff_sub_q  <= x_w[W-1] ^ y_w[W-1];
        ex_q       <= {1'b0, xe};
        mx_q       <= mx_d;
        my_q       <= my_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        spec_flg_q <= spec_flg_d;
      end
      S_ADD:   sum_q <= sum_d;
      S_NORM: begin
        nm_q   <= nm_d;
        en_q   <= en_d;
        zero_q <= (v == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == S_ROUND) begin
      result_q <= res_d;
      flags_q  <= flg_d;
    end
  end

endmodule
